// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small byte FIFO in front of the
// serialiser. A producer pushes bytes over a valid/ready handshake. The FSM
// drains the FIFO and sends each byte LSB first, framed by one start bit and
// one stop bit. When the FIFO still holds data at the end of a stop bit, the
// next frame starts with no idle gap.
//
// Ports
//   CLK      system clock, rising edge
//   RESET    synchronous reset, active high; aborts any frame in flight
//   data_i   byte to transmit
//   valid_i  data_i valid; a byte is written when valid_i && ready_o
//   ready_o  FIFO not full
//   TXD      serial line, idle high, driven straight from a flop
//   busy_o   frame in progress or FIFO non-empty
//   count_o  bytes currently held in the FIFO (0..FIFO_DEPTH)
module uart_tx #(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int BAUD        = 115_200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [7:0]                  data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic                        TXD,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);

  localparam int CPB = CLK_FREQ_HZ / BAUD;
  localparam int BW  = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          txd, txd_n;
  logic          push, pop, bit_end, have_data;

  assign ready_o   = (count != CNT_FULL);
  assign push      = valid_i && ready_o;
  assign have_data = (count != '0);
  assign bit_end   = (baud == BAUD_LAST);

  assign TXD     = txd;
  assign count_o = count;
  assign busy_o  = (state != IDLE) || have_data;

  // Next-state logic. The line level for the coming bit is computed here and
  // registered, so TXD only moves on bit boundaries and never glitches.
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    txd_n     = txd;
    pop       = 1'b0;

    // The baud counter reloads at every bit boundary, so frames never drift.
    if (state != IDLE) baud_n = bit_end ? '0 : baud + BAUD_ONE;

    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (have_data) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          baud_n  = '0;
          state_n = START;
          txd_n   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
          txd_n     = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            txd_n     = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          // Back-to-back: go straight to the next start bit when data waits.
          if (have_data) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
            txd_n   = 1'b0;
          end else begin
            state_n = IDLE;
            txd_n   = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      txd     <= txd_n;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= data_i;
  end

endmodule
